// File: rtl/test_bed_if.sv
// rtl/test_bed_if.sv - store-sniff and result signals between the processor side and the answer monitor
interface test_bed_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;

  modport master (
    output addr, data, wen,
    input  error_num, duration, finish
  );

  modport slave (
    input  addr, data, wen,
    output error_num, duration, finish
  );
endinterface

// File: rtl/test_bed.sv
// rtl/test_bed.sv - answer monitor: compares processor stores against a golden table, counts errors and cycles
// GOLDEN packs ANS_NUM entries of {2'b00, addr[29:0], data[31:0]}, entry 0 in the least significant 64 bits.
module test_bed #(
  parameter int                      ANS_NUM = 16,
  parameter logic [ANS_NUM*64-1:0]   GOLDEN  = '0
) (
  input  logic        clk,
  input  logic        rst,
  test_bed_if.slave   mon
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CHECK  = 2'd1,
    S_DONE   = 2'd2,
    S_UNUSED = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(ANS_NUM - 1);

  state_e      curstate, curstate_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  error_num_q, error_num_d;
  logic [15:0] duration_q, duration_d;

  // Table padded to 256 entries so the 8-bit index selects it without width tricks.
  logic [29:0] gaddr_rom [256];
  logic [31:0] gdata_rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    if (g < ANS_NUM) begin : g_used
      assign gaddr_rom[g] = GOLDEN[g*64+32 +: 30];
      assign gdata_rom[g] = GOLDEN[g*64 +: 32];
    end else begin : g_pad
      assign gaddr_rom[g] = '0;
      assign gdata_rom[g] = '0;
    end
  end

  logic [29:0] gaddr;
  logic [31:0] gdata;
  logic        hit;
  logic        data_ok;

  assign gaddr   = gaddr_rom[idx_q];
  assign gdata   = gdata_rom[idx_q];
  assign hit     = mon.wen && (mon.addr == gaddr);
  assign data_ok = (mon.data == gdata);

  always_comb begin
    curstate_d  = curstate;
    idx_d       = idx_q;
    error_num_d = error_num_q;
    duration_d  = duration_q;

    if (curstate != S_DONE && duration_q != 16'hFFFF) begin
      duration_d = duration_q + 16'd1;
    end

    case (curstate)
      S_WAIT: begin
        if (hit && data_ok) begin
          idx_d      = 8'd1;
          curstate_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          if (!data_ok && error_num_q != 8'hFF) begin
            error_num_d = error_num_q + 8'd1;
          end
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            curstate_d = S_DONE;
          end
        end
      end
      S_DONE: begin
      end
      default: begin
        curstate_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curstate    <= S_WAIT;
      idx_q       <= 8'd0;
      error_num_q <= 8'd0;
      duration_q  <= 16'd0;
    end else begin
      curstate    <= curstate_d;
      idx_q       <= idx_d;
      error_num_q <= error_num_d;
      duration_q  <= duration_d;
    end
  end

  assign mon.error_num = error_num_q;
  assign mon.duration  = duration_q;
  assign mon.finish    = (curstate == S_DONE);

endmodule

// File: tb/tb_test_bed.sv
// tb/tb_test_bed.sv - directed self-checking bench for the answer monitor
module tb_test_bed;

  localparam logic [29:0] A0 = 30'h0000_0100;
  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [29:0] A1 = 30'h0000_0104;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [29:0] A2 = 30'h2000_0000;
  localparam logic [31:0] D2 = 32'h8000_0001;
  localparam logic [29:0] A3 = 30'h3FFF_FFFF;
  localparam logic [31:0] D3 = 32'h0000_0000;
  localparam logic [255:0] G4 = {2'b00, A3, D3, 2'b00, A2, D2, 2'b00, A1, D1, 2'b00, A0, D0};

  localparam logic [29:0] B0 = 30'h0000_0010;
  localparam logic [31:0] E0 = 32'hA5A5_A5A5;
  localparam logic [29:0] B1 = 30'h0000_0014;
  localparam logic [31:0] E1 = 32'h5A5A_5A5A;
  localparam logic [127:0] G2 = {2'b00, B1, E1, 2'b00, B0, E0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  test_bed_if m ();
  test_bed_if m2 ();

  test_bed #(.ANS_NUM(4), .GOLDEN(G4)) dut (.clk(clk), .rst(rst), .mon(m));
  test_bed #(.ANS_NUM(2), .GOLDEN(G2)) dut2 (.clk(clk), .rst(rst), .mon(m2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m.wen = 1'b0;
    m2.wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic store_at(input int which, input int k, input logic [29:0] a, input logic [31:0] d);
    while (cyc < k - 1) tick();
    if (which == 0) begin
      m.addr = a; m.data = d; m.wen = 1'b1;
    end else begin
      m2.addr = a; m2.data = d; m2.wen = 1'b1;
    end
    tick();
    m.wen = 1'b0;
    m2.wen = 1'b0;
  endtask

  initial begin
    m.addr = '0; m.data = '0; m.wen = 1'b0;
    m2.addr = '0; m2.data = '0; m2.wen = 1'b0;

    // reset then idle
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_state", 32'(dut.curstate), 0);
    check("rst_finish", 32'(m.finish), 0);
    check("rst_err", 32'(m.error_num), 0);
    check("rst_dur", 32'(m.duration), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (100) tick();
    check("idle_state", 32'(dut.curstate), 0);
    check("idle_finish", 32'(m.finish), 0);
    check("idle_err", 32'(m.error_num), 0);
    check("idle_dur", 32'(m.duration), 100);

    // all-correct run
    do_reset();
    store_at(0, 10, A0, D0);
    check("ok_state1", 32'(dut.curstate), 1);
    store_at(0, 20, A1, D1);
    store_at(0, 30, A2, D2);
    check("ok_state_mid", 32'(dut.curstate), 1);
    check("ok_finish_early", 32'(m.finish), 0);
    store_at(0, 40, A3, D3);
    check("ok_finish", 32'(m.finish), 1);
    check("ok_state2", 32'(dut.curstate), 2);
    check("ok_err", 32'(m.error_num), 0);
    check("ok_dur", 32'(m.duration), 40);
    store_at(0, 45, A0, D0 ^ 32'h1);
    repeat (10) tick();
    check("done_dur_frozen", 32'(m.duration), 40);
    check("done_err_frozen", 32'(m.error_num), 0);
    check("done_state", 32'(dut.curstate), 2);

    // two wrong answers, plus an out-of-order answer address that must be ignored
    do_reset();
    store_at(0, 5, A0, D0);
    store_at(0, 8, A3, D3 ^ 32'h1);
    check("wr_skip_err", 32'(m.error_num), 0);
    check("wr_skip_idx", 32'(dut.idx_q), 1);
    store_at(0, 10, A1, D1 ^ 32'h1);
    check("wr_err1", 32'(m.error_num), 1);
    store_at(0, 12, A2, D2);
    store_at(0, 14, A3, D3 ^ 32'h1);
    check("wr_finish", 32'(m.finish), 1);
    check("wr_err2", 32'(m.error_num), 2);
    check("wr_dur", 32'(m.duration), 14);

    // wrong first answer and noise
    do_reset();
    store_at(0, 3, A0, D0 ^ 32'h8000_0000);
    store_at(0, 4, 30'h0000_0055, D0);
    store_at(0, 5, A0 ^ 30'h2000_0000, D0);
    store_at(0, 6, A1, D1);
    check("noise_state", 32'(dut.curstate), 0);
    check("noise_err", 32'(m.error_num), 0);
    store_at(0, 9, A0, D0);
    check("noise_state1", 32'(dut.curstate), 1);
    check("noise_idx", 32'(dut.idx_q), 1);

    // duration saturation in S_WAIT
    do_reset();
    tick();
    tick();
    force dut.duration_q = 16'hFF00;
    tick();
    release dut.duration_q;
    repeat (300) tick();
    check("sat_dur", 32'(m.duration), 32'hFFFF);
    check("sat_state", 32'(dut.curstate), 0);

    // error_num saturation
    do_reset();
    store_at(0, 2, A0, D0);
    force dut.error_num_q = 8'd254;
    tick();
    release dut.error_num_q;
    store_at(0, 5, A1, ~D1);
    check("esat_255", 32'(m.error_num), 255);
    store_at(0, 6, A2, ~D2);
    check("esat_hold", 32'(m.error_num), 255);
    store_at(0, 7, A3, D3);
    check("esat_finish", 32'(m.finish), 1);
    check("esat_final", 32'(m.error_num), 255);

    // asynchronous abort mid-S_CHECK
    do_reset();
    store_at(0, 3, A0, D0);
    store_at(0, 5, A1, D1 ^ 32'h4);
    check("abort_pre_err", 32'(m.error_num), 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_state", 32'(dut.curstate), 0);
    check("abort_idx", 32'(dut.idx_q), 0);
    check("abort_err", 32'(m.error_num), 0);
    check("abort_dur", 32'(m.duration), 0);
    check("abort_finish", 32'(m.finish), 0);

    // matching store while reset is still high is ignored
    @(negedge clk);
    m.addr = A0; m.data = D0; m.wen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m.wen = 1'b0;
    cyc = 0;
    check("rstedge_state", 32'(dut.curstate), 0);
    tick();
    check("rstedge_dur", 32'(m.duration), 1);

    // two-entry table: S_CHECK lasts one matched store
    do_reset();
    store_at(1, 3, B0, E0);
    check("n2_state1", 32'(dut2.curstate), 1);
    store_at(1, 5, B1, E1);
    check("n2_finish", 32'(m2.finish), 1);
    check("n2_err", 32'(m2.error_num), 0);
    check("n2_dur", 32'(m2.duration), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
